// File: rtl/alu_pkg.sv
// Opcode map and FSM encoding for the multicycle ALU; also consumed by the control unit.
package alu_pkg;

  localparam int ALU_OPW = 5;
  typedef logic [ALU_OPW-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 5'h01;
  localparam alu_op_t ALU_SUB  = 5'h02;
  localparam alu_op_t ALU_MUL  = 5'h03;
  localparam alu_op_t ALU_SLL  = 5'h04;
  localparam alu_op_t ALU_SRL  = 5'h05;
  localparam alu_op_t ALU_AND  = 5'h06;
  localparam alu_op_t ALU_OR   = 5'h07;
  localparam alu_op_t ALU_XOR  = 5'h08;
  localparam alu_op_t ALU_NAND = 5'h09;
  localparam alu_op_t ALU_XNOR = 5'h0A;
  localparam alu_op_t ALU_SGE  = 5'h0B;
  localparam alu_op_t ALU_SEQ  = 5'h0C;
  localparam alu_op_t ALU_NOR  = 5'h0D;
  localparam alu_op_t ALU_SLT  = 5'h0E;
  localparam alu_op_t ALU_SNE  = 5'h0F;
  localparam alu_op_t ALU_SGT  = 5'h10;
  localparam alu_op_t ALU_SLE  = 5'h11;
  localparam alu_op_t ALU_SLTU = 5'h12;
  localparam alu_op_t ALU_SRA  = 5'h13;
  localparam alu_op_t ALU_MULU = 5'h14;
  localparam alu_op_t ALU_DIV  = 5'h15;
  localparam alu_op_t ALU_DIVU = 5'h16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_iter_op(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_MULU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// The final step is combinational so the caller can register it on the done cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count_reg;
  logic             is_div_reg;
  logic             neg_lo_reg;
  logic             neg_hi_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign sgn_a = is_signed_op(op) & a[WIDTH-1];
  assign sgn_b = is_signed_op(op) & b[WIDTH-1];
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;

  // Multiply: hi_reg accumulates, lo_reg holds the multiplier and receives product bits.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
    assign addend[gi] = d_reg[gi] & lo_reg[0];
  end

  assign mul_sum     = {1'b0, hi_reg} + {1'b0, addend};
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

  // Divide: hi_reg is the partial remainder, lo_reg shifts the dividend out and quotient in.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_next;
  logic [WIDTH-1:0] div_lo_next;

  assign div_shift   = {hi_reg, lo_reg[WIDTH-1]};
  assign div_diff    = div_shift - {1'b0, d_reg};
  assign div_ok      = ~div_diff[WIDTH];
  assign div_hi_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_next = {lo_reg[WIDTH-2:0], div_ok};

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign prod     = {mul_hi_next, mul_lo_next};
  assign prod_fix = neg_lo_reg ? -prod : prod;

  always_comb begin
    lo = prod_fix[WIDTH-1:0];
    hi = prod_fix[2*WIDTH-1:WIDTH];
    if (is_div_reg) begin
      if (dbz_reg) begin
        lo = '1;
        hi = a_reg;
      end else begin
        lo = neg_lo_reg ? -div_lo_next : div_lo_next;
        hi = neg_hi_reg ? -div_hi_next : div_hi_next;
      end
    end
  end

  assign done = (count_reg == CW'(1));
  assign dbz  = dbz_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      dbz_reg    <= 1'b0;
      a_reg      <= '0;
      d_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (start) begin
      count_reg  <= CW'(WIDTH);
      is_div_reg <= is_div_op(op);
      neg_lo_reg <= sgn_a ^ sgn_b;
      neg_hi_reg <= sgn_a;
      dbz_reg    <= is_div_op(op) && (b == '0);
      a_reg      <= a;
      d_reg      <= is_div_op(op) ? mag_b : mag_a;
      hi_reg     <= '0;
      lo_reg     <= is_div_op(op) ? mag_a : mag_b;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
      hi_reg    <= is_div_reg ? div_hi_next : mul_hi_next;
      lo_reg    <= is_div_reg ? div_lo_next : mul_lo_next;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/compare ops plus iterative mul/div.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic             Zero,
  output logic             DivByZero,
  output logic             Busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             zero_reg;
  logic             dbz_reg;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic             md_dbz;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] quick_next;
  logic [SHW-1:0]   shamt;

  assign InReady   = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && OutReady);
  assign OutValid  = (state_reg == ST_DONE);
  assign Busy      = (state_reg == ST_BUSY);
  assign ALUResult   = result_reg;
  assign ALUResultHi = result_hi_reg;
  assign Zero      = zero_reg;
  assign DivByZero = dbz_reg;

  assign accept   = InValid & InReady;
  assign md_start = accept & is_iter_op(ALUControl);
  assign shamt    = B[SHW-1:0];

  always_comb begin
    quick_next = '0;
    case (ALUControl)
      ALU_ADD:  quick_next = A + B;
      ALU_SUB:  quick_next = A - B;
      ALU_SLL:  quick_next = A << shamt;
      ALU_SRL:  quick_next = A >> shamt;
      ALU_SRA:  quick_next = $signed(A) >>> shamt;
      ALU_AND:  quick_next = A & B;
      ALU_OR:   quick_next = A | B;
      ALU_XOR:  quick_next = A ^ B;
      ALU_NAND: quick_next = ~(A & B);
      ALU_XNOR: quick_next = ~(A ^ B);
      ALU_NOR:  quick_next = ~(A | B);
      ALU_SLT:  quick_next = WIDTH'($signed(A) < $signed(B));
      ALU_SLTU: quick_next = WIDTH'(A < B);
      ALU_SGE:  quick_next = WIDTH'($signed(A) >= $signed(B));
      ALU_SEQ:  quick_next = WIDTH'(A == B);
      ALU_SNE:  quick_next = WIDTH'(A != B);
      ALU_SGT:  quick_next = WIDTH'($signed(A) > $signed(B));
      ALU_SLE:  quick_next = WIDTH'($signed(A) <= $signed(B));
      default:  quick_next = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk  (Clk),
    .srst (Reset),
    .start(md_start),
    .op   (ALUControl),
    .a    (A),
    .b    (B),
    .done (md_done),
    .lo   (md_lo),
    .hi   (md_hi),
    .dbz  (md_dbz)
  );

  // A pop in DONE with a simultaneous accept is handled exactly like an IDLE accept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_iter_op(ALUControl)) begin
              state_reg <= ST_BUSY;
            end else begin
              state_reg     <= ST_DONE;
              result_reg    <= quick_next;
              result_hi_reg <= '0;
              zero_reg      <= (quick_next == '0);
              dbz_reg       <= 1'b0;
            end
          end else if ((state_reg == ST_DONE) && OutReady) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state_reg     <= ST_DONE;
            result_reg    <= md_lo;
            result_hi_reg <= md_hi;
            zero_reg      <= (md_lo == '0);
            dbz_reg       <= md_dbz;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  ctrl;
  logic [31:0] a, b, res, res_hi;
  logic        zero, dbz, busy;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [4:0]  ctrl8;
  logic [7:0]  a8, b8, res8, res_hi8;
  logic        zero8, dbz8, busy8;

  int n_cmp = 0;
  int n_bad = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
    .ALUControl(ctrl), .A(a), .B(b), .OutValid(out_valid), .OutReady(out_ready),
    .ALUResult(res), .ALUResultHi(res_hi), .Zero(zero), .DivByZero(dbz), .Busy(busy)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .InValid(in_valid8), .InReady(in_ready8),
    .ALUControl(ctrl8), .A(a8), .B(b8), .OutValid(out_valid8), .OutReady(out_ready8),
    .ALUResult(res8), .ALUResultHi(res_hi8), .Zero(zero8), .DivByZero(dbz8), .Busy(busy8)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_dbz,
                        input int exp_lat);
    int lat;
    int guard;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; ctrl = op; a = av; b = bv;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, "_inready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // scramble operands to show they were latched at accept
    in_valid = 1'b0; ctrl = ALU_ADD; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_lo"}, 64'(res), 64'(exp_lo));
    check_val({tag, "_hi"}, 64'(res_hi), 64'(exp_hi));
    check_val({tag, "_zero"}, 64'(zero), 64'(exp_lo == 32'd0));
    check_val({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
    $display("txn %s op=%02h a=%08h b=%08h -> lo=%08h hi=%08h z=%0b dbz=%0b lat=%0d",
             tag, op, av, bv, res, res_hi, zero, dbz, lat);
  endtask

  task automatic run8(input string tag, input logic [4:0] op, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] exp_lo, input logic [7:0] exp_hi, input int exp_lat);
    int lat;
    @(negedge clk);
    out_ready8 = 1'b1; in_valid8 = 1'b1; ctrl8 = op; a8 = av; b8 = bv;
    check_val({tag, "_inready"}, 64'(in_ready8), 64'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_lo"}, 64'(res8), 64'(exp_lo));
    check_val({tag, "_hi"}, 64'(res_hi8), 64'(exp_hi));
    $display("txn %s op=%02h a=%02h b=%02h -> lo=%02h hi=%02h lat=%0d", tag, op, av, bv, res8, res_hi8, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; ctrl = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; ctrl8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("reset_flags", 64'({in_ready, out_valid, busy, zero, dbz}), 64'(5'b10000));
    check_val("reset_res", 64'({res_hi, res}), 64'd0);

    // reset during a multiply aborts it
    run_op("add_pre", ALU_ADD, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1);
    @(negedge clk);
    in_valid = 1'b1; ctrl = ALU_MUL; a = 32'hFFFF_FFFD; b = 32'd7; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("mul_busy", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_inready", 64'(in_ready), 64'd1);
    check_val("abort_outvalid", 64'(out_valid), 64'd0);
    check_val("abort_res", 64'(res), 64'd0);
    check_val("abort_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check_val("abort_discard", 64'(out_valid), 64'd0);
    $display("txn reset_mid_mul -> inready=%0b outvalid=%0b res=%08h", in_ready, out_valid, res);
    run_op("add_post", ALU_ADD, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1);

    // back-to-back single-cycle ops, one result per cycle
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; ctrl = ALU_SUB; a = 32'd3; b = 32'd3;
    @(negedge clk);
    check_val("b2b_sub", 64'({out_valid, zero, res}), {31'd0, 1'b1, 1'b1, 32'd0});
    check_val("b2b_inready", 64'(in_ready), 64'd1);
    $display("txn b2b SUB 3-3 -> %08h z=%0b", res, zero);
    ctrl = ALU_SLT; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clk);
    check_val("b2b_slt", 64'({out_valid, zero, res}), {31'd0, 1'b1, 1'b0, 32'd1});
    $display("txn b2b SLT -1<1 -> %08h", res);
    ctrl = ALU_SRA; a = 32'h8000_0000; b = 32'd4;
    @(negedge clk);
    check_val("b2b_sra", 64'({out_valid, res}), {31'd0, 1'b1, 32'hF800_0000});
    $display("txn b2b SRA -> %08h", res);
    in_valid = 1'b0;

    // iterative ops
    run_op("mul",     ALU_MUL,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("mulu",    ALU_MULU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'd1,         1'b0, 33);
    run_op("div",     ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("divu_z",  ALU_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       1'b1, 33);
    run_op("div_min", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 33);
    run_op("divu",    ALU_DIVU, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33);

    // assorted single-cycle ops and boundaries
    run_op("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 1'b0, 1);
    run_op("nor",      ALU_NOR,  32'h0F0F_0000, 32'h00F0_F000, 32'hF000_0FFF, 32'd0, 1'b0, 1);
    run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 1'b0, 1);
    run_op("sge",      ALU_SGE,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 1'b0, 1);
    run_op("sle",      ALU_SLE,  32'hFFFF_FFFF, 32'd1,         32'd1,         32'd0, 1'b0, 1);
    run_op("sll_mask", ALU_SLL,  32'd1,         32'd36,        32'd16,        32'd0, 1'b0, 1);
    run_op("undef",    5'h1F,    32'd9,         32'd9,         32'd0,         32'd0, 1'b0, 1);

    // backpressure then pop-and-accept on the same edge
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ctrl = ALU_ADD; a = 32'd1; b = 32'd2;
    @(negedge clk);
    a = 32'd10; b = 32'd20;
    check_val("bp_first", 64'({out_valid, res}), {31'd0, 1'b1, 32'd3});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_hold", 64'({out_valid, in_ready, res}), {30'd0, 1'b1, 1'b0, 32'd3});
    end
    $display("txn backpressure held res=%08h inready=%0b", res, in_ready);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp_popacc", 64'({out_valid, res}), {31'd0, 1'b1, 32'd30});
    $display("txn pop+accept ADD 10+20 -> %08h", res);
    @(negedge clk);
    check_val("bp_drain", 64'(out_valid), 64'd0);

    // narrow instance
    run8("w8_mulu", ALU_MULU, 8'hFF, 8'hFF, 8'h01, 8'hFE, 9);
    run8("w8_sll",  ALU_SLL,  8'h01, 8'h0B, 8'h08, 8'h00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
